// File: rtl/qru_pkg.sv
// Shared definitions for the quotient/remainder unit.
// Optional result cache is enabled with QRU_RESULT_CACHE_EN.
package qru_pkg;

  localparam int QRU_W     = 32;
  localparam int QRU_CNT_W = $clog2(QRU_W) + 1;

  // qructl encoding, equal to func3[1:0]
  localparam logic [1:0] QRU_DIV  = 2'b00;
  localparam logic [1:0] QRU_DIVU = 2'b01;
  localparam logic [1:0] QRU_REM  = 2'b10;
  localparam logic [1:0] QRU_REMU = 2'b11;

  typedef enum logic [1:0] {
    QRU_IDLE = 2'd0,
    QRU_CALC = 2'd1,
    QRU_FIX  = 2'd2,
    QRU_DONE = 2'd3
  } qru_state_e;

endpackage

// File: rtl/qru_step.sv
// One restoring-division iteration. The partial remainder is widened by one
// bit so divisors with the MSB set are handled for unsigned operations.
module qru_step
  import qru_pkg::*;
#(
  parameter int W = QRU_W
) (
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] r_o,
  output logic [W-1:0] q_o
);

  logic [W:0] trial;

  assign trial = {r_i, q_i[W-1]} - {1'b0, d_i};

  // Keep the trial difference if it did not go negative, otherwise restore.
  always_comb begin
    r_o = {r_i[W-2:0], q_i[W-1]};
    q_o = {q_i[W-2:0], 1'b0};
    if (!trial[W]) begin
      r_o = trial[W-1:0];
      q_o = {q_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/qru.sv
// Iterative integer quotient/remainder unit for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow complete in one cycle; all other
// operations take W restoring steps plus a sign-fixup cycle.
// Defining QRU_RESULT_CACHE_EN adds a one-entry cache of the last computed
// quotient/remainder so a DIV followed by REM on the same operands is fast.
//
// state | meaning
// IDLE  | waiting for start, special cases resolved here
// CALC  | one restoring step per cycle, W cycles
// FIX   | apply signs, register divres
// DONE  | done pulse for one cycle
module qru
  import qru_pkg::*;
#(
  parameter int W = QRU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   qructl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] divres
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  qru_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0] r_q, q_q, d_q, divres_q;
  logic         rem_sel_q, qneg_q, rneg_q, busy_q, done_q;

  logic         signed_op, is_rem, div0, ovf, go_calc;
  logic [W-1:0] abs_a, abs_b, r_nxt, q_nxt, quo_fix, rem_fix;
  logic         cache_hit;
  logic [W-1:0] cache_val;

  assign signed_op = ~qructl[0];
  assign is_rem    = qructl[1];
  assign div0      = (b == '0);
  assign ovf       = signed_op && (a == MOST_NEG) && (b == '1);
  assign abs_a     = (signed_op && a[W-1]) ? -a : a;
  assign abs_b     = (signed_op && b[W-1]) ? -b : b;
  assign quo_fix   = qneg_q ? -q_q : q_q;
  assign rem_fix   = rneg_q ? -r_q : r_q;
  assign go_calc   = (state_q == QRU_IDLE) && start && !div0 && !ovf && !cache_hit;

  qru_step #(.W(W)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_nxt),
    .q_o (q_nxt)
  );

`ifdef QRU_RESULT_CACHE_EN
  logic         cv_q, cs_q;
  logic [W-1:0] ca_q, cb_q, cquo_q, crem_q;

  assign cache_hit = cv_q && (ca_q == a) && (cb_q == b) && (cs_q == signed_op);
  assign cache_val = is_rem ? crem_q : cquo_q;

  // Capture operands when a computation starts, results when it finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q   <= 1'b0;
      cs_q   <= 1'b0;
      ca_q   <= '0;
      cb_q   <= '0;
      cquo_q <= '0;
      crem_q <= '0;
    end else if (go_calc) begin
      cv_q <= 1'b0;
      cs_q <= signed_op;
      ca_q <= a;
      cb_q <= b;
    end else if (state_q == QRU_FIX) begin
      cv_q   <= 1'b1;
      cquo_q <= quo_fix;
      crem_q <= rem_fix;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_val = '0;
`endif

  // Control FSM with registered busy/done/divres.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= QRU_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      divres_q  <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        QRU_IDLE: begin
          if (start) begin
            if (div0) begin
              divres_q <= is_rem ? a : '1;
              done_q   <= 1'b1;
              state_q  <= QRU_DONE;
            end else if (ovf) begin
              divres_q <= is_rem ? '0 : a;
              done_q   <= 1'b1;
              state_q  <= QRU_DONE;
            end else if (cache_hit) begin
              divres_q <= cache_val;
              done_q   <= 1'b1;
              state_q  <= QRU_DONE;
            end else begin
              rem_sel_q <= is_rem;
              qneg_q    <= signed_op & (a[W-1] ^ b[W-1]);
              rneg_q    <= signed_op & a[W-1];
              q_q       <= abs_a;
              d_q       <= abs_b;
              r_q       <= '0;
              cnt_q     <= CNT_LOAD;
              busy_q    <= 1'b1;
              state_q   <= QRU_CALC;
            end
          end
        end
        QRU_CALC: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= QRU_FIX;
          end
        end
        QRU_FIX: begin
          divres_q <= rem_sel_q ? rem_fix : quo_fix;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= QRU_DONE;
        end
        default: begin
          state_q <= QRU_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign divres = divres_q;

endmodule

// File: tb/tb_qru.sv
// Directed bench for qru: table of operations with hand-computed results and
// latencies, plus reset-mid-operation and start-while-busy sequences.
module tb_qru;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  qructl = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] divres;

  int n_total = 0;
  int n_pass  = 0;

`ifdef QRU_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  // Reference view of the one-entry result cache.
  bit          m_valid = 1'b0;
  bit          m_signed = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;

  qru dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .qructl (qructl),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .divres (divres)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    bit s;
    s = ~op[0];
    if (bv == 32'h0) return 1;
    if (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 1;
    if (CACHE && m_valid && m_a == av && m_b == bv && m_signed == s) return 1;
    m_valid  = 1'b1;
    m_a      = av;
    m_b      = bv;
    m_signed = s;
    return 34;
  endfunction

  // Start one operation, scramble the inputs afterwards, and report latency,
  // result, busy in cycle 1, and done in the cycle after the pulse.
  task automatic run_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output logic [31:0] res,
                        output logic busy1, output logic done_after);
    lat = -1;
    res = 'x;
    busy1 = 1'b0;
    done_after = 1'b1;
    @(negedge clk);
    start = 1'b1; qructl = op; a = av; b = bv;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busy1 = busy;
        start = 1'b0;
        a = $urandom; b = $urandom; qructl = 2'($urandom_range(0, 3));
      end
      if (done) begin
        lat = k;
        res = divres;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int          lat, elat;
    logic [31:0] res;
    logic        busy1, done_after;
    int          ndone, first_done;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[6]  = '{2'b00, 32'h1234,       32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{2'b11, 32'h1234,       32'd0,          32'h1234};
    vecs[8]  = '{2'b01, 32'h1234,       32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{2'b10, 32'h1234,       32'd0,          32'h1234};
    vecs[10] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[11] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[13] = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1};
    vecs[14] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE};
    vecs[15] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000};
    vecs[16] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14};
    vecs[17] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE};
    vecs[18] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[19] = '{2'b00, 32'd0,          32'd5,          32'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_divres", divres, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      elat = exp_latency(vecs[i].op, vecs[i].av, vecs[i].bv);
      run_op(vecs[i].op, vecs[i].av, vecs[i].bv, lat, res, busy1, done_after);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(elat));
      chk($sformatf("vec%0d_busy_c1", i), {31'd0, busy1}, {31'd0, (elat > 1)});
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, done_after}, 32'd0);
    end

    // Asynchronous reset during a long operation.
    @(negedge clk);
    start = 1'b1; qructl = 2'b01; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midop_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_busy", {31'd0, busy}, 32'd0);
    chk("midop_rst_done", {31'd0, done}, 32'd0);
    chk("midop_rst_divres", divres, 32'd0);
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    elat = exp_latency(2'b01, 32'd50, 32'd5);
    run_op(2'b01, 32'd50, 32'd5, lat, res, busy1, done_after);
    chk("post_rst_result", res, 32'd10);
    chk("post_rst_latency", 32'(lat), 32'(elat));

    // Second start while busy must be ignored and not queued.
    elat = exp_latency(2'b01, 32'd1000, 32'd3);
    ndone = 0;
    first_done = -1;
    @(negedge clk);
    start = 1'b1; qructl = 2'b01; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = (k == 4);
      if (k == 4) begin qructl = 2'b11; a = 32'd77; b = 32'd5; end
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k;
          chk("busy_start_result", divres, 32'd333);
        end
      end
    end
    chk("busy_start_latency", 32'(first_done), 32'(elat));
    chk("busy_start_pulses", 32'(ndone), 32'd1);
    chk("busy_start_hold", divres, 32'd333);

    // DIV followed by REM on the same operands.
    elat = exp_latency(2'b00, 32'd100, 32'd7);
    run_op(2'b00, 32'd100, 32'd7, lat, res, busy1, done_after);
    chk("pair_div_result", res, 32'd14);
    chk("pair_div_latency", 32'(lat), 32'(elat));
    elat = exp_latency(2'b10, 32'd100, 32'd7);
    run_op(2'b10, 32'd100, 32'd7, lat, res, busy1, done_after);
    chk("pair_rem_result", res, 32'd2);
    chk("pair_rem_latency", 32'(lat), 32'(elat));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
